// File: rtl/ace_controller.sv
// ACE master-port control FSM: sequences AW/W/B, AR/R and AC/CR/CD handshakes and drives datapath command strobes.
// Optional ACE_RETRY_EN: reissue non-OKAY transactions up to MAX_RETRY times.
module ace_controller #(
  parameter int MAX_RETRY = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic read_req,
  input  logic write_req,
  input  logic invalid_req,
  output logic ace_ready,
  input  logic B_okay,
  input  logic R_okay,
  input  logic invalid,
  input  logic snoop_miss,
  input  logic response,
  input  logic response_data,
  output logic make_unique_o,
  output logic read_shared_o,
  output logic write_clean_o,
  output logic read_resp_en,
  output logic ac_enable,
  input  logic AW_READY,
  output logic AW_VALID,
  input  logic W_READY,
  output logic W_VALID,
  input  logic B_VALID,
  output logic B_READY,
  input  logic AR_READY,
  output logic AR_VALID,
  input  logic R_VALID,
  output logic R_READY,
  input  logic AC_VALID,
  output logic AC_READY,
  input  logic CR_READY,
  output logic CR_VALID,
  input  logic CD_READY,
  output logic CD_VALID
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_W_ADDR   = 4'd1,
    S_W_DATA   = 4'd2,
    S_W_RESP   = 4'd3,
    S_R_ADDR   = 4'd4,
    S_R_RESP   = 4'd5,
    S_R_DONE   = 4'd6,
    S_SNP_LOOK = 4'd7,
    S_SNP_CR   = 4'd8,
    S_SNP_CRCD = 4'd9
  } state_e;

  state_e state_q, state_d;
  logic   unique_q, unique_d;
  logic   cr_done_q, cr_done_d;
  logic   cd_done_q, cd_done_d;
  logic   cr_hs_s, cd_hs_s;

`ifdef ACE_RETRY_EN
  localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);
  logic [3:0] retry_q, retry_d;
  logic       retry_max_s;
  assign retry_max_s = (retry_q == MAX_RETRY_C);
`else
  logic unused_max_retry_s;
  assign unused_max_retry_s = (MAX_RETRY > 0);
`endif

  // A snoop channel counts as done once its READY has been seen, now or earlier.
  assign cr_hs_s = cr_done_q | CR_READY;
  assign cd_hs_s = cd_done_q | CD_READY;

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      unique_q  <= 1'b0;
      cr_done_q <= 1'b0;
      cd_done_q <= 1'b0;
`ifdef ACE_RETRY_EN
      retry_q   <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      unique_q  <= unique_d;
      cr_done_q <= cr_done_d;
      cd_done_q <= cd_done_d;
`ifdef ACE_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    unique_d  = unique_q;
    cr_done_d = cr_done_q;
    cd_done_d = cd_done_q;
`ifdef ACE_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        cr_done_d = 1'b0;
        cd_done_d = 1'b0;
`ifdef ACE_RETRY_EN
        retry_d   = 4'd0;
`endif
        if (write_req) begin
          state_d = S_W_ADDR;
        end else if (read_req) begin
          state_d  = S_R_ADDR;
          unique_d = 1'b0;
        end else if (invalid_req) begin
          state_d  = S_R_ADDR;
          unique_d = 1'b1;
        end else if (AC_VALID) begin
          state_d = S_SNP_LOOK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_W_ADDR: begin
        if (AW_READY) state_d = S_W_DATA;
        else          state_d = S_W_ADDR;
      end
      S_W_DATA: begin
        if (W_READY) state_d = S_W_RESP;
        else         state_d = S_W_DATA;
      end
      S_W_RESP: begin
        if (B_VALID) begin
`ifdef ACE_RETRY_EN
          if (B_okay || retry_max_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_W_ADDR;
            retry_d = retry_q + 4'd1;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          state_d = S_W_RESP;
        end
      end
      S_R_ADDR: begin
        if (AR_READY) state_d = S_R_RESP;
        else          state_d = S_R_ADDR;
      end
      S_R_RESP: begin
        if (R_VALID) begin
`ifdef ACE_RETRY_EN
          if (R_okay || retry_max_s) begin
            state_d = S_R_DONE;
          end else begin
            state_d = S_R_ADDR;
            retry_d = retry_q + 4'd1;
          end
`else
          // Without reissue a failed read is dropped and nothing is captured.
          if (R_okay) state_d = S_R_DONE;
          else        state_d = S_IDLE;
`endif
        end else begin
          state_d = S_R_RESP;
        end
      end
      S_R_DONE: state_d = S_IDLE;
      S_SNP_LOOK: begin
        if (response_data) begin
          state_d = S_SNP_CRCD;
        end else if (response || snoop_miss || invalid) begin
          state_d = S_SNP_CR;
        end else begin
          state_d = S_SNP_LOOK;
        end
      end
      S_SNP_CR: begin
        if (CR_READY) state_d = S_IDLE;
        else          state_d = S_SNP_CR;
      end
      S_SNP_CRCD: begin
        cr_done_d = cr_hs_s;
        cd_done_d = cd_hs_s;
        if (cr_hs_s && cd_hs_s) state_d = S_IDLE;
        else                    state_d = S_SNP_CRCD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode; AC_READY additionally yields to a pending master request.
  always_comb begin
    ace_ready     = 1'b0;
    AC_READY      = 1'b0;
    AW_VALID      = 1'b0;
    W_VALID       = 1'b0;
    B_READY       = 1'b0;
    AR_VALID      = 1'b0;
    R_READY       = 1'b0;
    CR_VALID      = 1'b0;
    CD_VALID      = 1'b0;
    ac_enable     = 1'b0;
    read_resp_en  = 1'b0;
    make_unique_o = 1'b0;
    read_shared_o = 1'b0;
    write_clean_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        ace_ready = 1'b1;
        AC_READY  = ~(write_req | read_req | invalid_req);
      end
      S_W_ADDR: begin
        AW_VALID      = 1'b1;
        write_clean_o = 1'b1;
      end
      S_W_DATA: begin
        W_VALID       = 1'b1;
        write_clean_o = 1'b1;
      end
      S_W_RESP: B_READY = 1'b1;
      S_R_ADDR: begin
        AR_VALID      = 1'b1;
        make_unique_o = unique_q;
        read_shared_o = ~unique_q;
      end
      S_R_RESP: begin
        R_READY       = 1'b1;
        make_unique_o = unique_q;
        read_shared_o = ~unique_q;
      end
      S_R_DONE:   read_resp_en = 1'b1;
      S_SNP_LOOK: ac_enable    = 1'b1;
      S_SNP_CR:   CR_VALID     = 1'b1;
      S_SNP_CRCD: begin
        CR_VALID = ~cr_done_q;
        CD_VALID = ~cd_done_q;
      end
      default: begin
        ace_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ace_controller.sv
// Scoreboard bench for ace_controller: per-cycle expected output vectors are queued with the stimulus and compared at the falling edge.
module tb_ace_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic read_req, write_req, invalid_req, B_okay, R_okay;
  logic invalid, snoop_miss, response, response_data;
  logic AW_READY, W_READY, B_VALID, AR_READY, R_VALID, AC_VALID, CR_READY, CD_READY;
  logic ace_ready, make_unique_o, read_shared_o, write_clean_o, read_resp_en, ac_enable;
  logic AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, AC_READY, CR_VALID, CD_VALID;

  // Input stimulus bits
  localparam logic [16:0] NONE    = 17'd0;
  localparam logic [16:0] I_WR    = 17'd1 << 16;
  localparam logic [16:0] I_RD    = 17'd1 << 15;
  localparam logic [16:0] I_INV   = 17'd1 << 14;
  localparam logic [16:0] I_BOK   = 17'd1 << 13;
  localparam logic [16:0] I_ROK   = 17'd1 << 12;
  localparam logic [16:0] I_SINV  = 17'd1 << 11;
  localparam logic [16:0] I_MISS  = 17'd1 << 10;
  localparam logic [16:0] I_RESP  = 17'd1 << 9;
  localparam logic [16:0] I_RDATA = 17'd1 << 8;
  localparam logic [16:0] I_AWR   = 17'd1 << 7;
  localparam logic [16:0] I_WRDY  = 17'd1 << 6;
  localparam logic [16:0] I_BV    = 17'd1 << 5;
  localparam logic [16:0] I_ARR   = 17'd1 << 4;
  localparam logic [16:0] I_RV    = 17'd1 << 3;
  localparam logic [16:0] I_ACV   = 17'd1 << 2;
  localparam logic [16:0] I_CRR   = 17'd1 << 1;
  localparam logic [16:0] I_CDR   = 17'd1 << 0;

  // Output vector bits
  localparam logic [13:0] O_RDY = 14'd1 << 13;
  localparam logic [13:0] O_ACR = 14'd1 << 12;
  localparam logic [13:0] O_AWV = 14'd1 << 11;
  localparam logic [13:0] O_WV  = 14'd1 << 10;
  localparam logic [13:0] O_BR  = 14'd1 << 9;
  localparam logic [13:0] O_ARV = 14'd1 << 8;
  localparam logic [13:0] O_RR  = 14'd1 << 7;
  localparam logic [13:0] O_CRV = 14'd1 << 6;
  localparam logic [13:0] O_CDV = 14'd1 << 5;
  localparam logic [13:0] O_ACE = 14'd1 << 4;
  localparam logic [13:0] O_RRE = 14'd1 << 3;
  localparam logic [13:0] O_MU  = 14'd1 << 2;
  localparam logic [13:0] O_RS  = 14'd1 << 1;
  localparam logic [13:0] O_WC  = 14'd1 << 0;
  localparam logic [13:0] IDLE_V = O_RDY | O_ACR;

  logic [13:0] outs_s;
  logic [13:0] exp_q [$];
  logic [13:0] got, ev;
  int checks = 0;
  int errors = 0;

  assign outs_s = {ace_ready, AC_READY, AW_VALID, W_VALID, B_READY, AR_VALID, R_READY,
                   CR_VALID, CD_VALID, ac_enable, read_resp_en, make_unique_o,
                   read_shared_o, write_clean_o};

  ace_controller dut (
    .clk(clk), .rst_n(rst_n),
    .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
    .ace_ready(ace_ready), .B_okay(B_okay), .R_okay(R_okay),
    .invalid(invalid), .snoop_miss(snoop_miss), .response(response),
    .response_data(response_data),
    .make_unique_o(make_unique_o), .read_shared_o(read_shared_o),
    .write_clean_o(write_clean_o), .read_resp_en(read_resp_en), .ac_enable(ac_enable),
    .AW_READY(AW_READY), .AW_VALID(AW_VALID), .W_READY(W_READY), .W_VALID(W_VALID),
    .B_VALID(B_VALID), .B_READY(B_READY), .AR_READY(AR_READY), .AR_VALID(AR_VALID),
    .R_VALID(R_VALID), .R_READY(R_READY), .AC_VALID(AC_VALID), .AC_READY(AC_READY),
    .CR_READY(CR_READY), .CR_VALID(CR_VALID), .CD_READY(CD_READY), .CD_VALID(CD_VALID)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [16:0] v);
    write_req     = v[16]; read_req   = v[15]; invalid_req = v[14];
    B_okay        = v[13]; R_okay     = v[12]; invalid     = v[11];
    snoop_miss    = v[10]; response   = v[9];  response_data = v[8];
    AW_READY      = v[7];  W_READY    = v[6];  B_VALID     = v[5];
    AR_READY      = v[4];  R_VALID    = v[3];  AC_VALID    = v[2];
    CR_READY      = v[1];  CD_READY   = v[0];
  endtask

  // Drive one cycle of stimulus, queue its expected outputs and move to the sampling edge.
  task automatic apply(input logic [16:0] s, input logic [13:0] e);
    drive(s);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(NONE);
    for (int i = 0; i < 20; i++) begin
      apply(NONE, IDLE_V);
      got = outs_s; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin
        errors++;
        $display("FAIL reset cycle %0d: got %b expected %b", i, got, ev);
      end
      next_cycle();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(NONE, IDLE_V);
      got = outs_s; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin
        errors++;
        $display("FAIL reset_release cycle %0d: got %b expected %b", i, got, ev);
      end
      next_cycle();
    end
  endtask

  task automatic test_write();
    logic [30:0] st [$];
    st.push_back({I_WR | I_AWR | I_WRDY | I_BV | I_BOK, O_RDY});
    st.push_back({I_AWR | I_WRDY | I_BV | I_BOK, O_AWV | O_WC});
    st.push_back({I_AWR | I_WRDY | I_BV | I_BOK, O_WV | O_WC});
    st.push_back({I_AWR | I_WRDY | I_BV | I_BOK, O_BR});
    st.push_back({NONE, IDLE_V});
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i][30:14], st[i][13:0]);
      got = outs_s; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin
        errors++;
        $display("FAIL write step %0d: got %b expected %b", i, got, ev);
      end
      next_cycle();
    end
  endtask

  task automatic test_retry();
    logic [30:0] st [$];
    st.push_back({I_WR | I_AWR | I_WRDY | I_BV, O_RDY});
    st.push_back({I_AWR | I_WRDY | I_BV, O_AWV | O_WC});
    st.push_back({I_AWR | I_WRDY | I_BV, O_WV | O_WC});
    st.push_back({I_AWR | I_WRDY | I_BV, O_BR});
`ifdef ACE_RETRY_EN
    st.push_back({I_AWR | I_WRDY | I_BV | I_BOK, O_AWV | O_WC});
    st.push_back({I_AWR | I_WRDY | I_BV | I_BOK, O_WV | O_WC});
    st.push_back({I_AWR | I_WRDY | I_BV | I_BOK, O_BR});
`endif
    st.push_back({NONE, IDLE_V});
    st.push_back({I_RD | I_ARR | I_RV, O_RDY});
    st.push_back({I_ARR | I_RV, O_ARV | O_RS});
    st.push_back({I_ARR | I_RV, O_RR | O_RS});
`ifdef ACE_RETRY_EN
    st.push_back({I_ARR | I_RV | I_ROK, O_ARV | O_RS});
    st.push_back({I_ARR | I_RV | I_ROK, O_RR | O_RS});
    st.push_back({NONE, O_RRE});
`endif
    st.push_back({NONE, IDLE_V});
    st.push_back({NONE, IDLE_V});
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i][30:14], st[i][13:0]);
      got = outs_s; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin
        errors++;
        $display("FAIL retry step %0d: got %b expected %b", i, got, ev);
      end
      next_cycle();
    end
  endtask

  task automatic test_invalid_stall();
    logic [30:0] st [$];
    st.push_back({I_INV, O_RDY});
    for (int k = 0; k < 3; k++) st.push_back({NONE, O_ARV | O_MU});
    st.push_back({I_ARR, O_ARV | O_MU});
    st.push_back({NONE, O_RR | O_MU});
    st.push_back({I_RV | I_ROK, O_RR | O_MU});
    st.push_back({NONE, O_RRE});
    st.push_back({NONE, IDLE_V});
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i][30:14], st[i][13:0]);
      got = outs_s; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin
        errors++;
        $display("FAIL invalid_stall step %0d: got %b expected %b", i, got, ev);
      end
      next_cycle();
    end
  endtask

  task automatic test_snoop_miss();
    logic [30:0] st [$];
    st.push_back({I_ACV, IDLE_V});
    st.push_back({NONE, O_ACE});
    st.push_back({I_MISS, O_ACE});
    st.push_back({NONE, O_CRV});
    st.push_back({I_CRR, O_CRV});
    st.push_back({NONE, IDLE_V});
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i][30:14], st[i][13:0]);
      got = outs_s; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin
        errors++;
        $display("FAIL snoop_miss step %0d: got %b expected %b", i, got, ev);
      end
      next_cycle();
    end
  endtask

  task automatic test_snoop_data();
    logic [30:0] st [$];
    st.push_back({I_ACV, IDLE_V});
    st.push_back({I_RDATA | I_MISS | I_SINV, O_ACE});
    st.push_back({I_CDR, O_CRV | O_CDV});
    for (int k = 0; k < 4; k++) st.push_back({NONE, O_CRV});
    st.push_back({I_CRR, O_CRV});
    st.push_back({NONE, IDLE_V});
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i][30:14], st[i][13:0]);
      got = outs_s; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin
        errors++;
        $display("FAIL snoop_data step %0d: got %b expected %b", i, got, ev);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [30:0] st [$];
    st.push_back({I_WR | I_ACV | I_AWR, O_RDY});
    st.push_back({I_ACV | I_AWR | I_WRDY, O_AWV | O_WC});
    st.push_back({I_ACV | I_WRDY, O_WV | O_WC});
    st.push_back({I_ACV | I_BV | I_BOK, O_BR});
    st.push_back({I_ACV, IDLE_V});
    st.push_back({I_RESP | I_SINV, O_ACE});
    st.push_back({I_CRR, O_CRV});
    st.push_back({NONE, IDLE_V});
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i][30:14], st[i][13:0]);
      got = outs_s; ev = exp_q.pop_front(); checks++;
      if (got !== ev) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %b expected %b", i, got, ev);
      end
      next_cycle();
    end
  endtask

  task automatic test_abort();
    apply(I_WR, O_RDY);
    got = outs_s; ev = exp_q.pop_front(); checks++;
    if (got !== ev) begin
      errors++;
      $display("FAIL abort_start: got %b expected %b", got, ev);
    end
    next_cycle();
    apply(NONE, O_AWV | O_WC);
    got = outs_s; ev = exp_q.pop_front(); checks++;
    if (got !== ev) begin
      errors++;
      $display("FAIL abort_waddr: got %b expected %b", got, ev);
    end
    #2;
    rst_n = 1'b0;
    exp_q.push_back(IDLE_V);
    #1;
    got = outs_s; ev = exp_q.pop_front(); checks++;
    if (got !== ev) begin
      errors++;
      $display("FAIL abort_reset: got %b expected %b", got, ev);
    end
    next_cycle();
    rst_n = 1'b1;
    apply(NONE, IDLE_V);
    got = outs_s; ev = exp_q.pop_front(); checks++;
    if (got !== ev) begin
      errors++;
      $display("FAIL abort_after: got %b expected %b", got, ev);
    end
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(NONE);
    #1;
    test_reset();
    test_write();
    test_retry();
    test_invalid_stall();
    test_snoop_miss();
    test_snoop_data();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
